// File: rtl/cpu_fetch.sv
// rtl/cpu_fetch.sv - instruction/operand fetch unit with ack timeout, pending jump and halt
// Reads memory at pc into IR or OPR on controller request; jumps load pc from OPR.
module cpu_fetch #(
  parameter int          ACK_TIMEOUT    = 15,
  parameter logic [7:0]  PC_RESET       = 8'h00,
  parameter logic [7:0]  STATE_FETCH_PC = 8'h01,
  parameter logic [7:0]  STATE_JUMP     = 8'h02,
  parameter logic [7:0]  STATE_TMP_JUMP = 8'h03,
  parameter logic [7:0]  STATE_HALT     = 8'h04,
  parameter logic [3:0]  T1             = 4'd1
) (
  input  logic       clk,
  input  logic       reset_cycle,
  input  logic [7:0] state,
  input  logic [3:0] cycle,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  output logic [7:0] instruction,
  output logic [7:0] operand,
  output logic [7:0] pc,
  output logic       busy,
  output logic       halted,
  output logic [1:0] err
);

  localparam logic [7:0] TMO_LIMIT = 8'(ACK_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HALT} fsm_e;

  fsm_e       fsm_q, fsm_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] addr_q, addr_d;
  logic       req_q, req_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] opr_q, opr_d;
  logic       busy_q, busy_d;
  logic       halted_q, halted_d;
  logic [1:0] err_q, err_d;
  logic [7:0] tmo_q, tmo_d;
  logic       tgt_ir_q, tgt_ir_d;
  logic       jmp_pend_q, jmp_pend_d;
  logic       halt_pend_q, halt_pend_d;

  logic       is_fetch, is_jump, is_halt;
  logic       jmp_now, halt_now, finish;
  logic [7:0] tmo_inc;

  assign is_fetch = (state == STATE_FETCH_PC);
  assign is_jump  = (state == STATE_JUMP) || (state == STATE_TMP_JUMP);
  assign is_halt  = (state == STATE_HALT);

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      fsm_q       <= S_IDLE;
      pc_q        <= PC_RESET;
      addr_q      <= 8'h00;
      req_q       <= 1'b0;
      ir_q        <= 8'h00;
      opr_q       <= 8'h00;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 2'b00;
      tmo_q       <= 8'h00;
      tgt_ir_q    <= 1'b0;
      jmp_pend_q  <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      ir_q        <= ir_d;
      opr_q       <= opr_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      tgt_ir_q    <= tgt_ir_d;
      jmp_pend_q  <= jmp_pend_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    req_d       = req_q;
    ir_d        = ir_q;
    opr_d       = opr_q;
    busy_d      = busy_q;
    halted_d    = halted_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    tgt_ir_d    = tgt_ir_q;
    jmp_pend_d  = jmp_pend_q;
    halt_pend_d = halt_pend_q;
    jmp_now     = 1'b0;
    halt_now    = 1'b0;
    finish      = 1'b0;
    tmo_inc     = tmo_q + 8'd1;

    case (fsm_q)
      S_IDLE: begin
        if (is_fetch) begin
          addr_d      = pc_q;
          req_d       = 1'b1;
          busy_d      = 1'b1;
          tgt_ir_d    = (cycle == T1);
          tmo_d       = 8'h00;
          jmp_pend_d  = 1'b0;
          halt_pend_d = 1'b0;
          fsm_d       = S_REQ;
        end else if (is_jump) begin
          pc_d = opr_q;
        end else if (is_halt) begin
          halted_d = 1'b1;
          fsm_d    = S_HALT;
        end
      end
      S_REQ: begin
        // Jump/halt requests seen during the read are folded in on the completing edge.
        jmp_now     = jmp_pend_q | is_jump;
        halt_now    = halt_pend_q | is_halt;
        jmp_pend_d  = jmp_now;
        halt_pend_d = halt_now;
        if (is_fetch) err_d[0] = 1'b1;
        if (mem_ack) begin
          if (tgt_ir_q) ir_d = mem_rdata;
          else          opr_d = mem_rdata;
          if (jmp_now) pc_d = tgt_ir_q ? opr_q : mem_rdata;
          else         pc_d = pc_q + 8'd1;
          finish = 1'b1;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_LIMIT) begin
            err_d[1] = 1'b1;
            if (jmp_now) pc_d = opr_q;
            finish = 1'b1;
          end
        end
        if (finish) begin
          req_d       = 1'b0;
          busy_d      = 1'b0;
          jmp_pend_d  = 1'b0;
          halt_pend_d = 1'b0;
          if (halt_now) begin
            halted_d = 1'b1;
            fsm_d    = S_HALT;
          end else begin
            fsm_d = S_IDLE;
          end
        end
      end
      S_HALT: begin
        req_d = 1'b0;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign instruction = ir_q;
  assign operand     = opr_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign err         = err_q;

endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 SHALL declare parameters (name, default, meaning): ACK_TIMEOUT, 15, max cycles mem_req waits for mem_ack; PC_RESET, 8'h00, PC value after reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_cycle  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port state  input  8  controller state code, compared against the STATE_* macros in parameters.v.
REQ-005 SHALL have port cycle  input  4  controller T-cycle number, compared against the T1..T8 macros.
REQ-006 SHALL have port mem_rdata  input  8  memory read data, valid when mem_ack=1.
REQ-007 SHALL have port mem_ack  input  1  memory read-complete strobe.
REQ-008 SHALL have port mem_req  output  1  memory read request.
REQ-009 SHALL have port mem_addr  output  8  memory read address.
REQ-010 SHALL have port instruction  output  8  instruction register (IR), fed to the controller.
REQ-011 SHALL have port operand  output  8  operand register (OPR).
REQ-012 SHALL have port pc  output  8  program counter.
REQ-013 SHALL have port busy  output  1  a read is in flight.
REQ-014 SHALL have port halted  output  1  sticky halt flag.
REQ-015 SHALL have port err  output  2  sticky errors: bit0 = fetch overrun, bit1 = ack timeout.

Function
REQ-016 SHALL implement FSM IDLE -> REQ -> IDLE; HALT is terminal until reset.
REQ-017 In IDLE with state==STATE_FETCH_PC sampled at a clock edge: mem_addr<=pc, mem_req<=1, record target (IR if cycle==T1, else OPR), busy<=1, go to REQ.
REQ-018 mem_addr SHALL stay stable while mem_req=1.
REQ-019 In REQ with mem_ack=1: write mem_rdata to the recorded target, pc<=pc+1 (8-bit, 8'hFF wraps to 8'h00), mem_req<=0, busy<=0, go to IDLE; read latency is 1 cycle after req plus memory wait.
REQ-020 mem_ack while mem_req=0 SHALL be ignored.
REQ-021 An 8-bit timeout counter SHALL clear on entry to REQ and increment each REQ cycle without ack. When it reaches ACK_TIMEOUT: drop mem_req, set err[1], leave target and pc unchanged, go to IDLE.
REQ-022 state==STATE_FETCH_PC while in REQ SHALL be ignored and SHALL set err[0].
REQ-023 state==STATE_JUMP or STATE_TMP_JUMP sampled in IDLE: pc<=operand.
REQ-024 If a jump state is sampled while in REQ, the jump SHALL be held pending and applied (pc<=operand, using the freshly written OPR) on the completion edge instead of the increment; on timeout it is applied using the old OPR.
REQ-025 state==STATE_HALT sampled in IDLE SHALL set halted=1 and enter HALT.
REQ-026 If STATE_HALT is sampled in REQ, the read SHALL finish (or time out) and then enter HALT.
REQ-027 In HALT, all state inputs SHALL be ignored, mem_req=0, and pc, IR and OPR held.
REQ-028 All other state codes SHALL leave every register unchanged.

Reset
REQ-029 reset_cycle=1 SHALL immediately (asynchronously) set pc=PC_RESET, mem_addr=0, mem_req=0, instruction=0, operand=0, busy=0, halted=0, err=0, timeout=0, no pending jump, FSM=IDLE.
REQ-030 Reset asserted mid-read SHALL abort the read; a mem_ack arriving after release SHALL be ignored.
REQ-031 The first fetch SHALL be honoured on the first clock edge after reset_cycle deasserts.

Verification
REQ-032 Reset, then FETCH_PC at T1, ack 2 cycles later with 8'h3C -> mem_addr=00, instruction=3C, pc=01, busy low after the ack edge.
REQ-033 pc=FF, FETCH_PC at T3, ack with 8'h20 -> operand=20, pc=00, instruction unchanged.
REQ-034 FETCH_PC at T3, JUMP sampled during REQ, ack with 8'h80 -> operand=80, pc=80 (not old pc+1).
REQ-035 FETCH_PC, no ack for 15 cycles -> mem_req drops, err=2'b10, pc unchanged; a late ack is ignored.
REQ-036 Second FETCH_PC during REQ -> err[0]=1, exactly one read. HALT sampled in IDLE -> halted=1, later FETCH_PC issues no mem_req.
REQ-037 reset_cycle pulsed while mem_req=1 -> all outputs return to reset values before the next edge, and an ack after release leaves IR=00.
